pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 90 +++++++++
 tb/tb_pipe_stage_skid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Control is masked when the output is not valid; flush squashes held entries.
module pipe_stage_skid #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 128,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_v;
    logic              skid_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              pop;

    assign in_ready  = ~skid_v;
    assign accept    = in_valid & ~skid_v;
    assign pop       = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            if (CLEAR_DATA) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            unique case (1'b1)
                skid_v: begin
                    // full: input is blocked, a pop promotes the skid entry
                    if (pop) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_v    <= 1'b0;
                    end
                end
                main_v & ~skid_v: begin
                    if (accept && pop) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (accept) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        skid_v    <= 1'b1;
                    end else if (pop) begin
                        main_v <= 1'b0;
                    end
                end
                ~main_v: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        main_v    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue model, on a clearing and a holding instance.
module tb_pipe_stage_skid;

    localparam int CW = 16;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          rdy0, ov0, rdy1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last0;
    logic [DW-1:0] last1;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .count(cnt0)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .count(cnt1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string t);
        logic [CW-1:0] ec;
        logic [DW-1:0] e0, e1;
        int n;
        n  = q.size();
        ec = (n > 0) ? q[0].c : '0;
        e0 = (n > 0) ? q[0].d : last0;
        e1 = (n > 0) ? q[0].d : last1;
        chk({t, ":rdy0"}, DW'(rdy0), DW'(n < 2));
        chk({t, ":ov0"},  DW'(ov0),  DW'(n > 0));
        chk({t, ":cnt0"}, DW'(cnt0), DW'(n));
        chk({t, ":oc0"},  DW'(oc0),  DW'(ec));
        chk({t, ":od0"},  od0, e0);
        chk({t, ":rdy1"}, DW'(rdy1), DW'(n < 2));
        chk({t, ":ov1"},  DW'(ov1),  DW'(n > 0));
        chk({t, ":cnt1"}, DW'(cnt1), DW'(n));
        chk({t, ":oc1"},  DW'(oc1),  DW'(ec));
        chk({t, ":od1"},  od1, e1);
    endtask

    // Drive one cycle starting at a negedge, advance the model on the edge,
    // then check at the following negedge.
    task automatic step(input string t, input logic iv, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy,
                        input logic fl);
        bit acc, pp;
        ent_t e;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (q.size() > 0) begin
            last0 = q[0].d;
            last1 = q[0].d;
        end
        if (fl) begin
            q.delete();
            last0 = '0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_all(t);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        last0     = '0;
        last1     = '0;
        #2;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 16; i++)
            step("stream", 1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
        step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("mask_ctrl", DW'(oc1), '0);
        chk("hold_data", od1, DW'(16));

        step("bp_a", 1'b1, 16'h11, DW'('h11), 1'b0, 1'b0);
        step("bp_b", 1'b1, 16'h22, DW'('h22), 1'b0, 1'b0);
        chk("bp_full_rdy", DW'(rdy0), '0);
        step("bp_blk", 1'b1, 16'h99, DW'('h99), 1'b0, 1'b0);
        step("bp_pop1", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_head2", od0, DW'('h22));
        step("bp_pop2", 1'b0, '0, '0, 1'b1, 1'b0);

        step("fl_a", 1'b1, 16'h33, DW'('h33), 1'b0, 1'b0);
        step("fl_b", 1'b1, 16'h44, DW'('h44), 1'b0, 1'b0);
        step("fl_full", 1'b1, 16'h55, DW'('h55), 1'b0, 1'b1);
        chk("fl_data0", od0, '0);
        step("fl_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        step("fp_a", 1'b1, 16'h77, DW'('h77), 1'b0, 1'b0);
        step("fp_pop", 1'b1, 16'h78, DW'('h78), 1'b1, 1'b1);
        step("fp_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        step("ar_a", 1'b1, 16'h5a, DW'('h5a), 1'b0, 1'b0);
        step("ar_b", 1'b1, 16'h5b, DW'('h5b), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        last0 = '0;
        last1 = '0;
        check_all("async_rst");
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");
        step("rst_push", 1'b1, 16'h66, DW'('h66), 1'b0, 1'b0);
        chk("rst_push_d", od0, DW'('h66));
        step("rst_pop", 1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            step("rand", 1'($urandom_range(0, 3) != 0), CW'($urandom), d,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
